up_exec: RTL and testbench
==========================

// Module: up_exec
// PURPOSE
//  Instruction decode/execute stage directly upstream of the 4x8 dual-port register file (up).
//  - Accepts 8-bit instructions over a valid/ready handshake.
//  - Reads two operands through the file's combinational read ports and computes an ALU result.
//  - Writes results back through the file's two write ports; keeps Z/C flags.
//  - Sole driver of the register file's select/write inputs.
// PARAMETERS
//  DATA_W     8  datapath width; must equal register file width
//  RF_ADDR_W  2  register select width (4 registers)
// PORTS
//  clk            in   1        clock; all state updates on rising edge
//  nRst           in   1        reset, synchronous, active-low
//  instr_valid    in   1        instruction/immediate byte valid
//  instr_data     in   8        [7:4] opcode, [3:2] rd, [1:0] rs; or the LDI immediate byte
//  instr_ready    out  1        stage can accept a byte this cycle
//  rf_sel_out_a   out  2        file read select A (= ir.rd)
//  rf_sel_out_b   out  2        file read select B (= ir.rs)
//  rf_data_out_a  in   8        file read data A
//  rf_data_out_b  in   8        file read data B
//  rf_we_a        out  1        file write enable A
//  rf_we_b        out  1        file write enable B
//  rf_sel_write_a out  2        file write select A
//  rf_sel_write_b out  2        file write select B
//  rf_data_in_a   out  8        file write data A
//  rf_data_in_b   out  8        file write data B
//  flag_z         out  1        zero flag
//  flag_c         out  1        carry/borrow/shift-out flag
//  busy           out  1        state != IDLE
//  illegal        out  1        one-cycle pulse on opcode 0xC-0xF
// BEHAVIOUR
//  Reset (nRst=0 at clk edge): state=IDLE, ir=0, all rf_* outputs/flags/illegal = 0.
//  - Reset mid-instruction aborts it; no write occurs on the reset edge.
//  FSM states: IDLE, EXEC, IMM, WB. instr_ready = (state==IDLE)|(state==IMM).
//  IDLE: on valid&ready, ir<=instr_data; opcode 0xB -> IMM, otherwise -> EXEC.
//  IMM: on valid, wr_data_a<=instr_data -> WB; stalls indefinitely without valid.
//  EXEC (1 cycle): A=rf_data_out_a (rd), B=rf_data_out_b (rs); compute and register write data -> WB.
//  - Exception: NOP, CMP and illegal opcodes return straight to IDLE.
//  WB (1 cycle): rf_we_* are high only in WB, registered; selects/data are stable in the same cycle -> IDLE.
//  Opcodes (result to rd unless noted):
//   0 NOP; 1 MOV =B; 2 ADD =A+B; 3 SUB =A-B; 4 AND; 5 OR; 6 XOR;
//   7 CMP flags of A-B, no write; 8 SHL =A<<1; 9 SHR =A>>1;
//   A SWP rd<=B via port A and rs<=A via port B; B LDI rd<=immediate.
//  Flags: updated at end of EXEC for opcodes 2,3,4,5,6,7,8,9 only.
//  - Z = (8-bit result==0).
//  - C: ADD carry-out (bit 8); SUB/CMP borrow (A<B unsigned); SHL old A[7]; SHR old A[0]; logic ops C=0.
//  - Arithmetic is modulo 256.
//  Write ports: rf_we_b is high only for SWP with rd!=rs.
//  - SWP with rd==rs: only rf_we_a (no-op value).
//  - rf_we_b is never asserted with rf_sel_write_b==rf_sel_write_a.
//  Latency: 3 cycles/instr (IDLE,EXEC,WB); LDI 3 cycles + immediate wait; NOP/CMP 2 cycles.
//  - Back-to-back: next accept on the cycle after WB.
//  - A result is visible on file reads from the cycle after WB, so no hazard exists.
//  illegal: pulses in the EXEC cycle for opcodes C-F; no write, flags unchanged.
// TESTING
//  1 reset, file at 01,02,03,04; ADD r0,r1 (0x21) -> WB: we_a=1, sel_write_a=0, data_in_a=03; Z=0 C=0
//  2 LDI r2 (0xB8) then byte 0xFF; ADD r2,r3 (0x2B) -> r2=0x03, C=1, Z=0; instr_ready high in IMM
//  3 SUB r1,r1 (0x35) -> r1=00, Z=1, C=0; CMP r0,r3 (0x73) -> no we, C=1, Z=0
//  4 SWP r0,r3 (0xA3) -> one WB cycle: we_a sel0 data 04, we_b sel3 data 01; SWP r1,r1 -> we_b=0
//  5 opcode 0xE0 -> illegal pulse 1 cycle, no we, flags held; instr_valid stuck high -> accept every 3rd cycle
//  6 nRst low during EXEC of ADD -> next cycle IDLE, we_a=we_b=0, flags 0; file contents unchanged

Source files
------------

// File: rtl/up_exec.sv
// Decode/execute stage feeding the 4x8 dual-port register file: fetches
// operands through the file's read ports, runs the ALU and writes results back.
module up_exec #(
  parameter int DATA_W    = 8,
  parameter int RF_ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 instr_valid,
  input  logic [7:0]           instr_data,
  output logic                 instr_ready,
  output logic [RF_ADDR_W-1:0] rf_sel_out_a,
  output logic [RF_ADDR_W-1:0] rf_sel_out_b,
  input  logic [DATA_W-1:0]    rf_data_out_a,
  input  logic [DATA_W-1:0]    rf_data_out_b,
  output logic                 rf_we_a,
  output logic                 rf_we_b,
  output logic [RF_ADDR_W-1:0] rf_sel_write_a,
  output logic [RF_ADDR_W-1:0] rf_sel_write_b,
  output logic [DATA_W-1:0]    rf_data_in_a,
  output logic [DATA_W-1:0]    rf_data_in_b,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 busy,
  output logic                 illegal
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] IMM  = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_CMP = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SWP = 4'hA;
  localparam logic [3:0] OP_LDI = 4'hB;

  logic [1:0] state;
  logic [7:0] ir;

  logic [3:0]           opcode;
  logic [RF_ADDR_W-1:0] rd;
  logic [RF_ADDR_W-1:0] rs;

  assign opcode = ir[7:4];
  assign rd     = ir[3:2];
  assign rs     = ir[1:0];

  assign rf_sel_out_a = rd;
  assign rf_sel_out_b = rs;
  assign instr_ready  = (state == IDLE) || (state == IMM);
  assign busy         = (state != IDLE);

  logic [DATA_W:0]   alu_wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              upd_flags;
  logic              do_write;

  // SWP reuses alu_res for the port-A value (B); port B carries A directly.
  always_comb begin
    alu_wide  = '0;
    alu_res   = '0;
    alu_c     = 1'b0;
    upd_flags = 1'b0;
    do_write  = 1'b0;
    case (opcode)
      OP_MOV: begin
        alu_res  = rf_data_out_b;
        do_write = 1'b1;
      end
      OP_ADD: begin
        alu_wide  = {1'b0, rf_data_out_a} + {1'b0, rf_data_out_b};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_c     = alu_wide[DATA_W];
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_wide  = {1'b0, rf_data_out_a} - {1'b0, rf_data_out_b};
        alu_res   = alu_wide[DATA_W-1:0];
        alu_c     = alu_wide[DATA_W];
        upd_flags = 1'b1;
        do_write  = (opcode == OP_SUB);
      end
      OP_AND: begin
        alu_res   = rf_data_out_a & rf_data_out_b;
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_OR: begin
        alu_res   = rf_data_out_a | rf_data_out_b;
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_XOR: begin
        alu_res   = rf_data_out_a ^ rf_data_out_b;
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_SHL: begin
        alu_res   = {rf_data_out_a[DATA_W-2:0], 1'b0};
        alu_c     = rf_data_out_a[DATA_W-1];
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_SHR: begin
        alu_res   = {1'b0, rf_data_out_a[DATA_W-1:1]};
        alu_c     = rf_data_out_a[0];
        upd_flags = 1'b1;
        do_write  = 1'b1;
      end
      OP_SWP: begin
        alu_res  = rf_data_out_b;
        do_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state          <= IDLE;
      ir             <= '0;
      rf_we_a        <= 1'b0;
      rf_we_b        <= 1'b0;
      rf_sel_write_a <= '0;
      rf_sel_write_b <= '0;
      rf_data_in_a   <= '0;
      rf_data_in_b   <= '0;
      flag_z         <= 1'b0;
      flag_c         <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      rf_we_a <= 1'b0;
      rf_we_b <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir      <= instr_data;
            state   <= (instr_data[7:4] == OP_LDI) ? IMM : EXEC;
            // Registered at accept so the pulse lines up with the EXEC cycle.
            illegal <= (instr_data[7:4] >= 4'hC);
          end
        end
        IMM: begin
          if (instr_valid) begin
            rf_data_in_a   <= instr_data;
            rf_sel_write_a <= rd;
            rf_we_a        <= 1'b1;
            state          <= WB;
          end
        end
        EXEC: begin
          if (upd_flags) begin
            flag_z <= (alu_res == '0);
            flag_c <= alu_c;
          end
          if (do_write) begin
            rf_we_a        <= 1'b1;
            rf_sel_write_a <= rd;
            rf_data_in_a   <= alu_res;
            if (opcode == OP_SWP) begin
              rf_we_b        <= (rd != rs);
              rf_sel_write_b <= rs;
              rf_data_in_b   <= rf_data_out_a;
            end
            state <= WB;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_up_exec.sv
// Bench for up_exec: behavioural register file plus an instruction-level
// reference model; directed cases followed by randomized instruction streams.
module tb_up_exec;

  logic       clk;
  logic       nRst;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic       instr_ready;
  logic [1:0] rf_sel_out_a, rf_sel_out_b;
  logic [7:0] rf_data_out_a, rf_data_out_b;
  logic       rf_we_a, rf_we_b;
  logic [1:0] rf_sel_write_a, rf_sel_write_b;
  logic [7:0] rf_data_in_a, rf_data_in_b;
  logic       flag_z, flag_c, busy, illegal;

  up_exec #(.DATA_W(8), .RF_ADDR_W(2)) dut (
    .clk(clk), .nRst(nRst),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .rf_sel_out_a(rf_sel_out_a), .rf_sel_out_b(rf_sel_out_b),
    .rf_data_out_a(rf_data_out_a), .rf_data_out_b(rf_data_out_b),
    .rf_we_a(rf_we_a), .rf_we_b(rf_we_b),
    .rf_sel_write_a(rf_sel_write_a), .rf_sel_write_b(rf_sel_write_b),
    .rf_data_in_a(rf_data_in_a), .rf_data_in_b(rf_data_in_b),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4x8 register file; load port lets the bench preset contents.
  logic [7:0] rf [4];
  logic       load_en;
  logic [7:0] load_val [4];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 4; i++) rf[i] <= load_val[i];
    end else begin
      if (rf_we_a) rf[rf_sel_write_a] <= rf_data_in_a;
      if (rf_we_b) rf[rf_sel_write_b] <= rf_data_in_b;
    end
  end
  assign rf_data_out_a = rf[rf_sel_out_a];
  assign rf_data_out_b = rf[rf_sel_out_b];

  int tests  = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural registers and flags.
  bit [7:0] mreg [4];
  bit       mz, mc;

  typedef struct {
    bit       wa, wb;
    bit [1:0] sa, sb;
    bit [7:0] da, db;
    bit       upd, z, c, ill;
    int       cyc;
  } pred_t;

  function automatic pred_t predict(input bit [7:0] ins, input bit [7:0] imm);
    pred_t p;
    int a, b, r;
    bit [3:0] op;
    op = ins[7:4];
    a  = mreg[ins[3:2]];
    b  = mreg[ins[1:0]];
    r  = 0;
    p  = '{default: 0};
    p.sa  = ins[3:2];
    p.sb  = ins[1:0];
    p.cyc = 3;
    case (op)
      4'h0: p.cyc = 2;
      4'h1: begin r = b; p.wa = 1; end
      4'h2: begin r = a + b; p.c = (r > 255); r = r % 256; p.wa = 1; p.upd = 1; end
      4'h3: begin p.c = (a < b); r = (a - b + 256) % 256; p.wa = 1; p.upd = 1; end
      4'h4: begin r = a & b; p.wa = 1; p.upd = 1; end
      4'h5: begin r = a | b; p.wa = 1; p.upd = 1; end
      4'h6: begin r = a ^ b; p.wa = 1; p.upd = 1; end
      4'h7: begin p.c = (a < b); r = (a - b + 256) % 256; p.upd = 1; p.cyc = 2; end
      4'h8: begin p.c = (a >= 128); r = (a * 2) % 256; p.wa = 1; p.upd = 1; end
      4'h9: begin p.c = (a % 2 == 1); r = a / 2; p.wa = 1; p.upd = 1; end
      4'hA: begin r = b; p.wa = 1; p.wb = (p.sa != p.sb); p.db = a[7:0]; end
      4'hB: begin r = imm; p.wa = 1; end
      default: begin p.ill = 1; p.cyc = 2; end
    endcase
    p.da = r[7:0];
    p.z  = (r == 0);
    return p;
  endfunction

  task automatic commit(input pred_t p);
    if (p.upd) begin mz = p.z; mc = p.c; end
    if (p.wa) mreg[p.sa] = p.da;
    if (p.wb) mreg[p.sb] = p.db;
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) chk($sformatf("reg%0d", i), rf[i], mreg[i]);
    chk("flag_z", flag_z, mz);
    chk("flag_c", flag_c, mc);
  endtask

  task automatic load_rf(input bit [7:0] v0, v1, v2, v3);
    load_val[0] = v0; load_val[1] = v1; load_val[2] = v2; load_val[3] = v3;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    mreg[0] = v0; mreg[1] = v1; mreg[2] = v2; mreg[3] = v3;
  endtask

  // Issues one instruction from an IDLE negedge and returns at the next IDLE negedge.
  task automatic run_instr(input bit [7:0] ins, input bit [7:0] imm, input int gap);
    pred_t p;
    int n, n_wa, n_wb, n_ill;
    logic [1:0] g_sa, g_sb;
    logic [7:0] g_da, g_db;
    p = predict(ins, imm);
    n = 0; n_wa = 0; n_wb = 0; n_ill = 0;
    g_sa = '0; g_sb = '0; g_da = '0; g_db = '0;
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr_data  = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    n = 1;
    if (ins[7:4] == 4'hB) begin
      p.cyc = 3 + gap;
      for (int g = 0; g < gap; g++) begin
        chk("ready_imm_stall", instr_ready, 1);
        chk("busy_imm_stall", busy, 1);
        @(negedge clk);
        n++;
      end
      chk("ready_imm", instr_ready, 1);
      instr_valid = 1'b1;
      instr_data  = imm;
      @(negedge clk);
      instr_valid = 1'b0;
      n++;
    end
    while (busy && n < 20) begin
      if (illegal) n_ill++;
      if (rf_we_a) begin n_wa++; g_sa = rf_sel_write_a; g_da = rf_data_in_a; end
      if (rf_we_b) begin
        n_wb++; g_sb = rf_sel_write_b; g_db = rf_data_in_b;
        chk("we_b_sel_distinct", rf_sel_write_b != rf_sel_write_a, 1);
      end
      @(negedge clk);
      n++;
    end
    if (busy) chk("timeout_busy", busy, 0);
    chk("cycles", n, p.cyc);
    chk("we_a_count", n_wa, p.wa ? 1 : 0);
    chk("we_b_count", n_wb, p.wb ? 1 : 0);
    chk("illegal_count", n_ill, p.ill ? 1 : 0);
    if (p.wa) begin chk("sel_write_a", g_sa, p.sa); chk("data_in_a", g_da, p.da); end
    if (p.wb) begin chk("sel_write_b", g_sb, p.sb); chk("data_in_b", g_db, p.db); end
    commit(p);
    check_state();
  endtask

  initial begin
    int accepts;
    nRst = 1'b0; instr_valid = 1'b0; instr_data = '0; load_en = 1'b0;
    for (int i = 0; i < 4; i++) load_val[i] = '0;
    mz = 0; mc = 0;
    @(negedge clk);
    load_rf(8'h01, 8'h02, 8'h03, 8'h04);
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_we_a", rf_we_a, 0);
    chk("rst_we_b", rf_we_b, 0);
    chk("rst_sel_write", {rf_sel_write_a, rf_sel_write_b}, 0);
    chk("rst_data_in", {rf_data_in_a, rf_data_in_b}, 0);
    chk("rst_sel_out", {rf_sel_out_a, rf_sel_out_b}, 0);
    chk("rst_flags", {flag_z, flag_c, illegal}, 0);
    nRst = 1'b1;
    @(negedge clk);

    // 1: ADD r0,r1
    run_instr(8'h21, 8'h00, 0);
    chk("t1_r0", rf[0], 8'h03);
    // 2: LDI r2 0xFF, ADD r2,r3
    run_instr(8'hB8, 8'hFF, 2);
    chk("t2_ldi_r2", rf[2], 8'hFF);
    run_instr(8'h2B, 8'h00, 0);
    chk("t2_add_r2", rf[2], 8'h03);
    chk("t2_flags_zc", {flag_z, flag_c}, 2'b01);
    // 3: SUB r1,r1 and CMP r0,r3
    run_instr(8'h35, 8'h00, 0);
    chk("t3_sub_zc", {flag_z, flag_c}, 2'b10);
    run_instr(8'h73, 8'h00, 0);
    chk("t3_cmp_zc", {flag_z, flag_c}, 2'b01);
    // 4: SWP r0,r3 on fresh file; SWP r1,r1
    load_rf(8'h01, 8'h02, 8'h03, 8'h04);
    run_instr(8'hA3, 8'h00, 0);
    chk("t4_swp_r0", rf[0], 8'h04);
    chk("t4_swp_r3", rf[3], 8'h01);
    run_instr(8'hA5, 8'h00, 0);
    // 5: illegal opcode, then stuck-high valid
    run_instr(8'hE0, 8'h00, 0);
    accepts = 0;
    instr_valid = 1'b1;
    instr_data  = 8'h21;
    for (int i = 0; i < 9; i++) begin
      chk("stuck_ready", instr_ready, (i % 3 == 0) ? 1 : 0);
      if (instr_ready) accepts++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stuck_accepts", accepts, 3);
    for (int i = 0; i < 3; i++) commit(predict(8'h21, 8'h00));
    check_state();
    // 6: reset during EXEC of ADD aborts it
    instr_valid = 1'b1;
    instr_data  = 8'h21;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("t6_busy_exec", busy, 1);
    nRst = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    chk("t6_busy", busy, 0);
    chk("t6_we", {rf_we_a, rf_we_b}, 0);
    mz = 0; mc = 0;
    check_state();
    @(negedge clk);
    chk("t6_no_late_we", {rf_we_a, rf_we_b}, 0);
    check_state();

    // Random instruction streams
    for (int k = 0; k < 150; k++) begin
      if (k % 20 == 0)
        load_rf(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      run_instr(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
